// File: rtl/clock_time_counter.sv
// BCD hh:mm:ss 24-hour time-of-day counter advanced by rising edges of the divider's 1 Hz output,
// with a RUN / SET_HOUR / SET_MIN mode machine driven by single-cycle button pulses.
module clock_time_counter #(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       min_tick
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam logic [1:0] RST_HT = 2'(RESET_HOUR / 10);
  localparam logic [3:0] RST_HO = 4'(RESET_HOUR % 10);
  localparam logic [2:0] RST_MT = 3'(RESET_MIN / 10);
  localparam logic [3:0] RST_MO = 4'(RESET_MIN % 10);

  mode_e state;
  logic  tick_prev;
  logic  tick_edge;
  logic  [7:0] sec_nx;  // {wrap, tens, ones}
  logic  [7:0] min_nx;
  logic  [5:0] hr_nx;   // {tens, ones}

  // Increment of a 00..59 BCD pair; bit 7 flags the 59 -> 00 wrap.
  function automatic logic [7:0] next_base60(input logic [2:0] t, input logic [3:0] o);
    if (o != 4'd9)      return {1'b0, t, o + 4'd1};
    else if (t != 3'd5) return {1'b0, t + 3'd1, 4'd0};
    else                return {1'b1, 3'd0, 4'd0};
  endfunction

  function automatic logic [5:0] next_hour(input logic [1:0] t, input logic [3:0] o);
    if (t == 2'd2 && o == 4'd3) return 6'd0;
    else if (o == 4'd9)         return {t + 2'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  assign tick_edge = tick_in & ~tick_prev;
  assign mode      = state;

  always_comb begin
    sec_nx = next_base60(sec_tens, sec_ones);
    min_nx = next_base60(min_tens, min_ones);
    hr_nx  = next_hour(hr_tens, hr_ones);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      tick_prev <= 1'b0;
      min_tick  <= 1'b0;
      hr_tens   <= RST_HT;
      hr_ones   <= RST_HO;
      min_tens  <= RST_MT;
      min_ones  <= RST_MO;
      sec_tens  <= 3'd0;
      sec_ones  <= 4'd0;
    end else begin
      tick_prev <= tick_in;
      min_tick  <= 1'b0;
      // mode_pulse wins over a same-cycle tick or inc, which are dropped.
      case (state)
        RUN: begin
          if (mode_pulse) begin
            state    <= SET_HOUR;
            sec_tens <= 3'd0;
            sec_ones <= 4'd0;
          end else if (tick_edge) begin
            {sec_tens, sec_ones} <= sec_nx[6:0];
            if (sec_nx[7]) begin
              min_tick             <= 1'b1;
              {min_tens, min_ones} <= min_nx[6:0];
              if (min_nx[7]) {hr_tens, hr_ones} <= hr_nx;
            end
          end
        end
        SET_HOUR: begin
          if (mode_pulse)     state <= SET_MIN;
          else if (inc_pulse) {hr_tens, hr_ones} <= hr_nx;
        end
        SET_MIN: begin
          if (mode_pulse) begin
            state    <= RUN;
            sec_tens <= 3'd0;
            sec_ones <= 4'd0;
          end else if (inc_pulse) begin
            {min_tens, min_ones} <= min_nx[6:0];
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: directed scenarios plus random stimulus, checked every cycle
// against a seconds-of-day behavioural model, with literal spot checks along the way.
module tb_clock_time_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in, mode_pulse, inc_pulse;
  logic [1:0] hr_tens, p_hr_tens;
  logic [3:0] hr_ones, p_hr_ones;
  logic [2:0] min_tens, p_min_tens;
  logic [3:0] min_ones, p_min_ones;
  logic [2:0] sec_tens, p_sec_tens;
  logic [3:0] sec_ones, p_sec_ones;
  logic [1:0] mode, p_mode;
  logic       min_tick, p_min_tick;

  int   errors = 0;
  int   checks = 0;
  int   mt_seen = 0;
  logic check_en = 1'b0;

  // model: time as seconds of day, mode as 0/1/2, last sampled tick_in
  int   m_t = 0;
  int   m_mode = 0;
  logic m_prev = 1'b0;
  logic m_mt = 1'b0;

  clock_time_counter dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .mode_pulse(mode_pulse), .inc_pulse(inc_pulse),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .min_tick(min_tick)
  );

  clock_time_counter #(.RESET_HOUR(7), .RESET_MIN(30)) dut_p (
    .clk(clk), .reset(reset), .tick_in(tick_in), .mode_pulse(mode_pulse), .inc_pulse(inc_pulse),
    .hr_tens(p_hr_tens), .hr_ones(p_hr_ones), .min_tens(p_min_tens), .min_ones(p_min_ones),
    .sec_tens(p_sec_tens), .sec_ones(p_sec_ones), .mode(p_mode), .min_tick(p_min_tick)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int mi, input int s, input int md);
    chk({name, "_hr_tens"},  int'(hr_tens),  h / 10);
    chk({name, "_hr_ones"},  int'(hr_ones),  h % 10);
    chk({name, "_min_tens"}, int'(min_tens), mi / 10);
    chk({name, "_min_ones"}, int'(min_ones), mi % 10);
    chk({name, "_sec_tens"}, int'(sec_tens), s / 10);
    chk({name, "_sec_ones"}, int'(sec_ones), s % 10);
    chk({name, "_mode"},     int'(mode),     md);
  endtask

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_prev = 1'b0; m_mt = 1'b0;
  endtask

  task automatic model_update();
    automatic int  h  = m_t / 3600;
    automatic int  mi = (m_t / 60) % 60;
    automatic int  s  = m_t % 60;
    automatic logic rise = tick_in && !m_prev;
    m_prev = tick_in;
    m_mt   = 1'b0;
    case (m_mode)
      0: begin
        if (mode_pulse) begin
          m_mode = 1;
          m_t = h * 3600 + mi * 60;
        end else if (rise) begin
          m_t  = (m_t + 1) % 86400;
          m_mt = (m_t % 60 == 0);
        end
      end
      1: begin
        if (mode_pulse)     m_mode = 2;
        else if (inc_pulse) m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
      end
      default: begin
        if (mode_pulse) begin
          m_mode = 0;
          m_t = h * 3600 + mi * 60;
        end else if (inc_pulse) begin
          m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
        end
      end
    endcase
  endtask

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("cmp_hr_tens",  int'(hr_tens),  (m_t / 3600) / 10);
      chk("cmp_hr_ones",  int'(hr_ones),  (m_t / 3600) % 10);
      chk("cmp_min_tens", int'(min_tens), ((m_t / 60) % 60) / 10);
      chk("cmp_min_ones", int'(min_ones), ((m_t / 60) % 60) % 10);
      chk("cmp_sec_tens", int'(sec_tens), (m_t % 60) / 10);
      chk("cmp_sec_ones", int'(sec_ones), (m_t % 60) % 10);
      chk("cmp_mode",     int'(mode),     m_mode);
      chk("cmp_min_tick", int'(min_tick), int'(m_mt));
      if (min_tick) mt_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic t, input logic m, input logic i);
    tick_in = t; mode_pulse = m; inc_pulse = i;
    @(posedge clk);
    model_update();
    #1;
    mode_pulse = 1'b0; inc_pulse = 1'b0;
  endtask

  task automatic pulse_tick();
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic inc_n(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic mode_press();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // from RUN: set hh:mm through the set modes, ending back in RUN at hh:mm:00
  task automatic set_time(input int h, input int mi);
    mode_press();
    inc_n((h - m_t / 3600 + 24) % 24);
    mode_press();
    inc_n((mi - (m_t / 60) % 60 + 60) % 60);
    mode_press();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; tick_in = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check_en = 1'b1;
    chk_time("after_reset", 0, 0, 0, 0);
    chk("after_reset_min_tick", int'(min_tick), 0);

    // first rise shows one cycle later; falling edges do nothing
    step(1'b1, 1'b0, 1'b0);
    chk("first_rise_sec_ones", int'(sec_ones), 1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("held_high_sec_ones", int'(sec_ones), 1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("after_fall_sec_ones", int'(sec_ones), 1);
    repeat (3) pulse_tick();
    chk_time("four_ticks", 0, 0, 4, 0);

    // preload 23:59 and roll over the whole day
    mode_press();
    chk_time("enter_set_hour", 0, 0, 0, 1);
    inc_n(23);
    mode_press();
    inc_n(59);
    chk_time("preload", 23, 59, 0, 2);
    mode_press();
    mt_seen = 0;
    repeat (59) pulse_tick();
    chk_time("before_wrap", 23, 59, 59, 0);
    chk("no_min_tick_before_wrap", mt_seen, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_time("day_wrap", 0, 0, 0, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("min_tick_once", mt_seen, 1);

    // SET_HOUR from 12:34:56: seconds cleared, hour wraps, ticks frozen
    set_time(12, 34);
    repeat (56) pulse_tick();
    chk_time("at_123456", 12, 34, 56, 0);
    mode_press();
    chk_time("set_hour_entry", 12, 34, 0, 1);
    inc_n(13);
    chk_time("hour_wrap", 1, 34, 0, 1);
    repeat (2) pulse_tick();
    chk_time("frozen_in_set", 1, 34, 0, 1);

    // SET_MIN full lap, then resume counting from :00
    mode_press();
    inc_n(26);
    chk_time("min_to_zero", 1, 0, 0, 2);
    inc_n(60);
    chk_time("min_full_lap", 1, 0, 0, 2);
    mode_press();
    chk_time("back_to_run", 1, 0, 0, 0);
    pulse_tick();
    chk_time("resume_tick", 1, 0, 1, 0);

    // coincident mode_pulse with tick, then with inc
    set_time(0, 0);
    repeat (10) pulse_tick();
    chk_time("at_000010", 0, 0, 10, 0);
    step(1'b1, 1'b1, 1'b0);
    chk_time("mode_beats_tick", 0, 0, 0, 1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk_time("tick_lost", 0, 0, 0, 1);
    step(1'b0, 1'b1, 1'b1);
    chk_time("mode_beats_inc", 0, 0, 0, 2);
    step(1'b0, 1'b0, 1'b0);
    mode_press();

    // random stimulus, checked by the per-cycle compare
    for (int k = 0; k < 4000; k++) begin
      automatic logic t = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
      step(t, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    end

    // async reset in the middle of SET_MIN
    tick_in = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3 && m_mode != 2; k++) mode_press();
    inc_n(3);
    chk("pre_reset_mode", int'(mode), 2);
    chk("pre_reset_mode_p", int'(p_mode), 2);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk_time("async_reset", 0, 0, 0, 0);
    chk("p_hr_tens",  int'(p_hr_tens),  0);
    chk("p_hr_ones",  int'(p_hr_ones),  7);
    chk("p_min_tens", int'(p_min_tens), 3);
    chk("p_min_ones", int'(p_min_ones), 0);
    chk("p_sec_tens", int'(p_sec_tens), 0);
    chk("p_sec_ones", int'(p_sec_ones), 0);
    chk("p_mode",     int'(p_mode),     0);
    chk("p_min_tick", int'(p_min_tick), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    chk_time("post_reset_inc_ignored", 0, 0, 0, 0);
    pulse_tick();
    chk_time("post_reset_tick", 0, 0, 1, 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
